pc_gen_unit: RTL and testbench
==============================

# pc_gen_unit

Parametrised program-counter generator for the RISC-V core: owns the PC register, computes the next fetch address from sequential, jump, register-jump and conditional-branch sources, and handshakes with the fetch stage. It sits between execute, which resolves control transfers, and instruction fetch. It absorbs the old combinational next-PC select and adds stall handling, flush generation, alignment checking and optional trap/return redirection.

## Interface
Parameters:
- XLEN, 32, address/data width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- ILEN_BYTES, 4, sequential increment; must be 2 or 4. The alignment mask is ILEN_BYTES-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- pc_o  out  XLEN  current fetch address.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- pc_ready_i  in  1  fetch accepts pc_o this cycle.
- ctrl_valid_i  in  1  execute presents a resolved control instruction.
- ctrl_sel_i  in  2  00 seq, 01 jal (pc+imm), 10 jalr (rs1+imm), 11 cond branch.
- ctrl_taken_i  in  1  branch condition result; used only for sel 11.
- ctrl_pc_i  in  XLEN  PC of the control instruction.
- ctrl_imm_i  in  XLEN  sign-extended immediate.
- ctrl_rs1_i  in  XLEN  rs1 value for jalr.
- flush_o  out  1  kill younger in-flight instructions this cycle.
- misalign_o  out  1  one-cycle pulse: resolved target violated alignment.
- trap_valid_i  in  1  (PCU_TRAP_EN only) take trap.
- trap_vector_i  in  XLEN  (PCU_TRAP_EN only) trap handler address.
- mret_i  in  1  (PCU_TRAP_EN only) return from trap.
- epc_o  out  XLEN  (PCU_TRAP_EN only) saved exception PC.

## Operation
- Target computation:
  - sel 01: ctrl_pc_i + ctrl_imm_i.
  - sel 10: (ctrl_rs1_i + ctrl_imm_i) with bit 0 cleared.
  - sel 11: ctrl_pc_i + ctrl_imm_i if taken; otherwise ctrl_pc_i + ILEN_BYTES.
  - All sums are modulo 2^XLEN; wrap-around is silent.
- A redirect happens when ctrl_valid_i=1 and (sel is 01 or 10, or (sel is 11 and taken)). A not-taken branch and sel 00 are not redirects.
- Misaligned target means target & (ILEN_BYTES-1) is nonzero on a redirect. In that case misalign_o=1 in the same cycle.
- Update priority each cycle: rst > trap/mret > redirect > advance (pc_valid_o & pc_ready_i → pc+ILEN_BYTES) > hold.
- A redirect overrides a stall: pc_ready_i=0 does not block it.
- When not ready, pc_o is held stable and pc_valid_o stays 1.
- flush_o is combinational: 1 in any cycle where a redirect, trap or mret is taken.

## Timing
- Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, flush_o=0, misalign_o=0, epc_o=0.
- pc_valid_o rises in the first cycle after rst deasserts and stays 1 thereafter.
- Redirect latency is 1 cycle: the target appears on pc_o in the cycle after ctrl_valid_i.
- Sequential advance latency is 1 cycle after the accepting handshake.
- A redirect and an accepting handshake in the same cycle: the redirect wins and the sequential PC is discarded.
- rst asserted mid-redirect: reset wins; no flush and no misalign pulse in that cycle.

## Configuration
- PCU_TRAP_EN undefined:
  - Trap/mret ports and epc_o are absent.
  - A misaligned target is still taken, with the low bits cleared (target & ~(ILEN_BYTES-1)); misalign_o pulses.
- PCU_TRAP_EN defined:
  - trap_valid_i loads pc_o ← trap_vector_i and epc_o ← current pc_o.
  - A misaligned redirect becomes an internal trap: pc_o ← trap_vector_i, epc_o ← ctrl_pc_i, misalign_o=1.
  - mret_i loads pc_o ← epc_o.
  - Simultaneous trap and mret: trap wins.

## Structure
- Package pc_pkg holds:
  - the ctrl_sel encodings PC_SEL_SEQ, PC_SEL_JAL, PC_SEL_JALR and PC_SEL_BR;
  - the default RESET_VECTOR constant.
- One sub-module, pc_target_calc: combinational target adder, taken select, alignment check and redirect flag.
- The PC register, handshake logic and EPC stay in the top level.

## Test plan
- Reset release with pc_ready_i=1 for 3 cycles → pc_valid_o=0 during rst; then pc_o = 0, 4, 8, 12.
- pc_ready_i=0 for 3 cycles at pc=8 → pc_o holds 8; it advances to 12 one cycle after ready returns.
- jal with ctrl_pc=0x100 and imm=-8 during a stall → flush_o=1 that cycle; pc_o=0xF8 the next cycle.
- Branch with sel 11 at ctrl_pc=0x40, imm=0x20:
  - taken=0 → no flush, PC continues sequentially;
  - taken=1 → flush_o=1, then pc_o=0x60.
- jalr with rs1=0xFFFF_FFFE and imm=4 → target wraps to 0x2, misalign_o=1.
  - Without PCU_TRAP_EN: pc_o=0x0.
  - With PCU_TRAP_EN (trap_vector=0x200): pc_o=0x200, epc_o=ctrl_pc.
- PCU_TRAP_EN: trap at pc=0x80, then mret → pc_o=trap_vector, then pc_o=0x80, with flush_o=1 on both.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings and defaults for the program-counter generator.
// Consumed by pc_target_calc and pc_gen_unit (optional trap path: PCU_TRAP_EN).
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ  = 2'b00,
    PC_SEL_JAL  = 2'b01,
    PC_SEL_JALR = 2'b10,
    PC_SEL_BR   = 2'b11
  } pc_sel_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-transfer target: adders, taken select, redirect flag
// and alignment check against the instruction-length mask.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic            ctrl_valid_i,
  input  logic [1:0]      ctrl_sel_i,
  input  logic            ctrl_taken_i,
  input  logic [XLEN-1:0] ctrl_pc_i,
  input  logic [XLEN-1:0] ctrl_imm_i,
  input  logic [XLEN-1:0] ctrl_rs1_i,
  output logic [XLEN-1:0] target_o,
  output logic            redirect_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

  logic [XLEN-1:0] pc_imm_s;
  logic [XLEN-1:0] rs1_imm_s;
  logic [XLEN-1:0] pc_seq_s;
  pc_sel_e         sel_s;

  assign pc_imm_s  = ctrl_pc_i + ctrl_imm_i;
  assign rs1_imm_s = ctrl_rs1_i + ctrl_imm_i;
  assign pc_seq_s  = ctrl_pc_i + XLEN'(ILEN_BYTES);
  assign sel_s     = pc_sel_e'(ctrl_sel_i);

  // Target select; a not-taken branch falls through and is not a redirect
  always_comb begin
    target_o   = pc_seq_s;
    redirect_o = 1'b0;
    case (sel_s)
      PC_SEL_SEQ: begin
        target_o   = pc_seq_s;
        redirect_o = 1'b0;
      end
      PC_SEL_JAL: begin
        target_o   = pc_imm_s;
        redirect_o = ctrl_valid_i;
      end
      PC_SEL_JALR: begin
        target_o   = {rs1_imm_s[XLEN-1:1], 1'b0};
        redirect_o = ctrl_valid_i;
      end
      PC_SEL_BR: begin
        if (ctrl_taken_i) begin
          target_o   = pc_imm_s;
          redirect_o = ctrl_valid_i;
        end else begin
          target_o   = pc_seq_s;
          redirect_o = 1'b0;
        end
      end
      default: begin
        target_o   = pc_seq_s;
        redirect_o = 1'b0;
      end
    endcase
  end

  assign misalign_o = redirect_o && ((target_o & ALIGN_MASK) != {XLEN{1'b0}});

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator: PC register, fetch handshake, redirect/flush.
// Define PCU_TRAP_EN to add trap/mret redirection and the saved EPC.
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter int              ILEN_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  input  logic            pc_ready_i,
  input  logic            ctrl_valid_i,
  input  logic [1:0]      ctrl_sel_i,
  input  logic            ctrl_taken_i,
  input  logic [XLEN-1:0] ctrl_pc_i,
  input  logic [XLEN-1:0] ctrl_imm_i,
  input  logic [XLEN-1:0] ctrl_rs1_i,
  output logic            flush_o,
`ifdef PCU_TRAP_EN
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] epc_o,
`endif
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic            valid_r;
  logic [XLEN-1:0] target_s;
  logic            redirect_s;
  logic            misalign_s;
  logic            flush_s;

  pc_target_calc #(
    .XLEN       (XLEN),
    .ILEN_BYTES (ILEN_BYTES)
  ) u_target (
    .ctrl_valid_i (ctrl_valid_i),
    .ctrl_sel_i   (ctrl_sel_i),
    .ctrl_taken_i (ctrl_taken_i),
    .ctrl_pc_i    (ctrl_pc_i),
    .ctrl_imm_i   (ctrl_imm_i),
    .ctrl_rs1_i   (ctrl_rs1_i),
    .target_o     (target_s),
    .redirect_o   (redirect_s),
    .misalign_o   (misalign_s)
  );

`ifdef PCU_TRAP_EN
  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] epc_next_s;

  // Next PC/EPC: external trap > mret > misaligned-redirect trap > redirect > advance
  always_comb begin
    pc_next_s  = pc_r;
    epc_next_s = epc_r;
    if (trap_valid_i) begin
      pc_next_s  = trap_vector_i;
      epc_next_s = pc_r;
    end else if (mret_i) begin
      pc_next_s = epc_r;
    end else if (redirect_s && misalign_s) begin
      pc_next_s  = trap_vector_i;
      epc_next_s = ctrl_pc_i;
    end else if (redirect_s) begin
      pc_next_s = target_s;
    end else if (valid_r && pc_ready_i) begin
      pc_next_s = pc_r + XLEN'(ILEN_BYTES);
    end else begin
      pc_next_s = pc_r;
    end
  end

  assign flush_s = trap_valid_i || mret_i || redirect_s;

  // Saved exception PC
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_r <= {XLEN{1'b0}};
    end else begin
      epc_r <= epc_next_s;
    end
  end

  assign epc_o = epc_r;
`else
  // Next PC: a misaligned redirect is still taken with its low bits cleared
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_s) begin
      pc_next_s = target_s & ~ALIGN_MASK;
    end else if (valid_r && pc_ready_i) begin
      pc_next_s = pc_r + XLEN'(ILEN_BYTES);
    end else begin
      pc_next_s = pc_r;
    end
  end

  assign flush_s = redirect_s;
`endif

  // PC register; valid rises on the first clock out of reset and stays high
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_VECTOR;
      valid_r <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      valid_r <= 1'b1;
    end
  end

  assign pc_o       = pc_r;
  assign pc_valid_o = valid_r;
  assign flush_o    = !rst && flush_s;
  assign misalign_o = !rst && misalign_s;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: the driver queues expected outputs per
// cycle, a negedge monitor pops and compares. Honours PCU_TRAP_EN.
module tb_pc_gen_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready = 1'b0;
  logic        ctrl_valid = 1'b0;
  logic [1:0]  ctrl_sel = 2'b00;
  logic        ctrl_taken = 1'b0;
  logic [31:0] ctrl_pc = 32'h0;
  logic [31:0] ctrl_imm = 32'h0;
  logic [31:0] ctrl_rs1 = 32'h0;
  logic        flush;
  logic        misalign;
  logic [31:0] epc;
`ifdef PCU_TRAP_EN
  logic        trap_valid = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] trap_vector = 32'h0000_0200;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .ILEN_BYTES   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (pc),
    .pc_valid_o    (pc_valid),
    .pc_ready_i    (pc_ready),
    .ctrl_valid_i  (ctrl_valid),
    .ctrl_sel_i    (ctrl_sel),
    .ctrl_taken_i  (ctrl_taken),
    .ctrl_pc_i     (ctrl_pc),
    .ctrl_imm_i    (ctrl_imm),
    .ctrl_rs1_i    (ctrl_rs1),
    .flush_o       (flush),
`ifdef PCU_TRAP_EN
    .trap_valid_i  (trap_valid),
    .trap_vector_i (trap_vector),
    .mret_i        (mret),
    .epc_o         (epc),
`endif
    .misalign_o    (misalign)
  );

`ifndef PCU_TRAP_EN
  assign epc = 32'h0;
`endif

  // Apply one cycle of stimulus just after the edge and queue what must be seen
  task automatic drv(input string nm, input logic r, input logic rd, input logic cv,
                     input logic [1:0] sel, input logic tk, input logic [31:0] cpc,
                     input logic [31:0] imm, input logic [31:0] rs1,
                     input logic tr, input logic mr,
                     input logic [31:0] e_pc, input logic e_v, input logic e_f,
                     input logic e_m, input logic [31:0] e_epc);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    pc_ready   = rd;
    ctrl_valid = cv;
    ctrl_sel   = sel;
    ctrl_taken = tk;
    ctrl_pc    = cpc;
    ctrl_imm   = imm;
    ctrl_rs1   = rs1;
`ifdef PCU_TRAP_EN
    trap_valid = tr;
    mret       = mr;
`else
    if (tr || mr) $display("note: trap stimulus ignored in %s", nm);
`endif
    e.name  = nm;
    e.pc    = e_pc;
    e.valid = e_v;
    e.flush = e_f;
    e.mis   = e_m;
    e.epc   = e_epc;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs of the current cycle against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (pc === e.pc && pc_valid === e.valid && flush === e.flush &&
          misalign === e.mis && epc === e.epc) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got pc=%h valid=%b flush=%b misalign=%b epc=%h, want pc=%h valid=%b flush=%b misalign=%b epc=%h",
                 e.name, pc, pc_valid, flush, misalign, epc,
                 e.pc, e.valid, e.flush, e.mis, e.epc);
      end
    end
  end

  localparam logic [31:0] NEG8 = 32'hFFFF_FFF8;

  initial begin
    //   name           rst  rdy  cv   sel    tk   ctrl_pc       imm           rs1           tr   mr    exp_pc        v    f    m    epc
    drv("reset",        1'b1,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0);
    drv("rst_redirect", 1'b1,1'b1,1'b1,2'b01,1'b0,32'h100,      32'h2,        32'h0,        1'b0,1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0);
    drv("rel0",         1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0);
    drv("rel1",         1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h0,        1'b1,1'b0,1'b0,32'h0);
    drv("seq4",         1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h4,        1'b1,1'b0,1'b0,32'h0);
    drv("seq8",         1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h8,        1'b1,1'b0,1'b0,32'h0);
    drv("stall1",       1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h8,        1'b1,1'b0,1'b0,32'h0);
    drv("stall2",       1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h8,        1'b1,1'b0,1'b0,32'h0);
    drv("stall3",       1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h8,        1'b1,1'b0,1'b0,32'h0);
    drv("jal_stall",    1'b0,1'b0,1'b1,2'b01,1'b0,32'h100,      NEG8,         32'h0,        1'b0,1'b0, 32'hC,        1'b1,1'b1,1'b0,32'h0);
    drv("br_nt",        1'b0,1'b1,1'b1,2'b11,1'b0,32'h40,       32'h20,       32'h0,        1'b0,1'b0, 32'hF8,       1'b1,1'b0,1'b0,32'h0);
    drv("br_t",         1'b0,1'b1,1'b1,2'b11,1'b1,32'h40,       32'h20,       32'h0,        1'b0,1'b0, 32'hFC,       1'b1,1'b1,1'b0,32'h0);
    drv("jalr_wrap",    1'b0,1'b1,1'b1,2'b10,1'b0,32'h300,      32'h4,        32'hFFFF_FFFE,1'b0,1'b0, 32'h60,       1'b1,1'b1,1'b1,32'h0);
`ifdef PCU_TRAP_EN
    drv("mis_trap",     1'b0,1'b1,1'b1,2'b01,1'b0,32'h0,        32'h80,       32'h0,        1'b0,1'b0, 32'h200,      1'b1,1'b1,1'b0,32'h300);
    drv("trap_in",      1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b1,1'b0, 32'h80,       1'b1,1'b1,1'b0,32'h300);
    drv("mret_in",      1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b1, 32'h200,      1'b1,1'b1,1'b0,32'h80);
    drv("mret_out",     1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h80,       1'b1,1'b0,1'b0,32'h80);
    drv("trap_mret",    1'b0,1'b0,1'b1,2'b01,1'b0,32'h0,        32'h40,       32'h0,        1'b1,1'b1, 32'h80,       1'b1,1'b1,1'b0,32'h80);
    drv("trap_wins",    1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h200,      1'b1,1'b0,1'b0,32'h80);
    drv("after_trap",   1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h204,      1'b1,1'b0,1'b0,32'h80);
`else
    drv("mis_clear",    1'b0,1'b1,1'b1,2'b01,1'b0,32'hFFFF_FFF0,32'h20,       32'h0,        1'b0,1'b0, 32'h0,        1'b1,1'b1,1'b0,32'h0);
    drv("jal_wrap",     1'b0,1'b1,1'b1,2'b01,1'b0,32'h10,       32'h6,        32'h0,        1'b0,1'b0, 32'h10,       1'b1,1'b1,1'b1,32'h0);
    drv("jal_mis",      1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h14,       1'b1,1'b0,1'b0,32'h0);
    drv("seq_after",    1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h18,       1'b1,1'b0,1'b0,32'h0);
    drv("hold_after",   1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0, 32'h18,       1'b1,1'b0,1'b0,32'h0);
`endif
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
